// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  // One bundle for every control line the sequencer drives into the pipeline.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
    logic error;
  } pipe_ctrl_t;

  // Whole pipeline held: nothing loads, nothing is zeroed.
  function automatic pipe_ctrl_t freeze_ctrl();
    pipe_ctrl_t c;
    c.pc_write     = 1'b0;
    c.if_id_write  = 1'b0;
    c.if_id_flush  = 1'b0;
    c.id_ex_bubble = 1'b0;
    c.pipe_freeze  = 1'b1;
    c.error        = 1'b0;
    return c;
  endfunction

  // Pipeline advances; a load-use stall outranks a taken branch because the
  // branch is re-evaluated once the stalled instruction moves on.
  function automatic pipe_ctrl_t advance_ctrl(input logic load_use,
                                              input logic branch_taken);
    pipe_ctrl_t c;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_bubble = 1'b0;
    c.pipe_freeze  = 1'b0;
    c.error        = 1'b0;
    if (load_use) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      c.if_id_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: merges load-use, branch flush and data-memory wait
// into one set of per-stage controls, with a wait watchdog and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WAIT_W   = DEF_WAIT_W,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              error_q;
  logic              error_d;
  pipe_ctrl_t        ctrl;
  logic              stall_inc;
  logic              flush_inc;

  // Decode controls from the registered state plus this cycle's requests, so
  // a stall bites in the same cycle it is raised; also pick the next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    ctrl       = freeze_ctrl();
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          ctrl       = freeze_ctrl();
          wait_cnt_d = WAIT_W'(1);
          state_d    = MEM_WAIT;
        end else begin
          ctrl = advance_ctrl(load_use_i, branch_taken_i);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          ctrl       = advance_ctrl(load_use_i, branch_taken_i);
          wait_cnt_d = '0;
          state_d    = RUN;
        end else if (wait_cnt_q == MAX_WAIT_V) begin
          state_d = HALT;
          error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ctrl.error = error_q;
  end

  // Perf-counter events: stalls only count while the pipeline is live.
  always_comb begin
    stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && !ctrl.pc_write;
    flush_inc = ctrl.if_id_flush;
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o     = ctrl.pc_write;
  assign if_id_write_o  = ctrl.if_id_write;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_bubble_o = ctrl.id_ex_bubble;
  assign pipe_freeze_o  = ctrl.pipe_freeze;
  assign error_o        = ctrl.error;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed checks of the stall/flush sequencer against a
// cycle-level behavioural model of the pipeline-control rules.
module tb_pipeline_hazard_ctrl;

  localparam int TB_CNT_W    = 4;
  localparam int TB_MAX_WAIT = 15;
  localparam int CNT_MAX     = (1 << TB_CNT_W) - 1;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic                load_use_i;
  logic                branch_taken_i;
  logic                dmem_req_i;
  logic                dmem_ack_i;
  logic                pc_write_o;
  logic                if_id_write_o;
  logic                if_id_flush_o;
  logic                id_ex_bubble_o;
  logic                pipe_freeze_o;
  logic                error_o;
  logic [TB_CNT_W-1:0] stall_cnt_o;
  logic [TB_CNT_W-1:0] flush_cnt_o;

  pipeline_hazard_ctrl #(
    .CNT_W    (TB_CNT_W),
    .WAIT_W   (4),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_write_o     (pc_write_o),
    .if_id_write_o  (if_id_write_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .error_o        (error_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: what the pipeline is doing, how long memory has kept
  // it waiting, and running totals of stalled and flushed cycles.
  typedef enum int {M_IDLE, M_RUN, M_WAIT, M_HALT} mode_t;
  mode_t m_mode;
  int    m_waits;
  bit    m_err;
  int    m_stall;
  int    m_flush;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_mode  = M_IDLE;
    m_waits = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic applyStimulus(input bit st, input bit lu, input bit br,
                               input bit req, input bit ack);
    bit held, e_pc, e_ifid, e_fl, e_bub, e_pf;
    start_i        = st;
    load_use_i     = lu;
    branch_taken_i = br;
    dmem_req_i     = req;
    dmem_ack_i     = ack;
    #1;
    held = (m_mode == M_IDLE) || (m_mode == M_HALT) ||
           (m_mode == M_RUN && req && !ack) || (m_mode == M_WAIT && !ack);
    if (held) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_pf = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; e_pf = 0;
    end else if (br) begin
      e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 0; e_pf = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_pf = 0;
    end
    checkOutput("pc_write",    32'(pc_write_o),     32'(e_pc));
    checkOutput("if_id_write", 32'(if_id_write_o),  32'(e_ifid));
    checkOutput("if_id_flush", 32'(if_id_flush_o),  32'(e_fl));
    checkOutput("id_ex_bubble",32'(id_ex_bubble_o), 32'(e_bub));
    checkOutput("pipe_freeze", 32'(pipe_freeze_o),  32'(e_pf));
    checkOutput("error",       32'(error_o),        32'(m_err));
    checkOutput("stall_cnt",   32'(stall_cnt_o),    32'(m_stall));
    checkOutput("flush_cnt",   32'(flush_cnt_o),    32'(m_flush));
    @(posedge clk_i);
    #1;
    if ((m_mode == M_RUN || m_mode == M_WAIT) && !e_pc && m_stall < CNT_MAX) m_stall++;
    if (e_fl && m_flush < CNT_MAX) m_flush++;
    case (m_mode)
      M_IDLE: if (st) m_mode = M_RUN;
      M_RUN:  if (req && !ack) begin m_mode = M_WAIT; m_waits = 1; end
      M_WAIT: begin
        if (ack) begin
          m_mode = M_RUN; m_waits = 0;
        end else if (m_waits == TB_MAX_WAIT) begin
          m_mode = M_HALT; m_err = 1'b1;
        end else begin
          m_waits++;
        end
      end
      default: m_mode = m_mode;
    endcase
  endtask

  // Hold reset across one edge, checking the idle outputs while it is active.
  task automatic doReset();
    rst_i = 1'b1;
    #2;
    modelReset();
    checkOutput("rst_pc_write",    32'(pc_write_o),    32'(0));
    checkOutput("rst_pipe_freeze", 32'(pipe_freeze_o), 32'(1));
    checkOutput("rst_error",       32'(error_o),       32'(0));
    checkOutput("rst_stall_cnt",   32'(stall_cnt_o),   32'(0));
    checkOutput("rst_flush_cnt",   32'(flush_cnt_o),   32'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 0; load_use_i = 0; branch_taken_i = 0;
    dmem_req_i = 0; dmem_ack_i = 0;
    modelReset();
    @(posedge clk_i);
    #1;
    doReset();

    $display("[TB] idle, start and basic run");
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run_after_start_pc", 32'(pc_write_o), 32'(1));

    $display("[TB] load-use with branch in the same cycle");
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("lu_stall_cnt", 32'(stall_cnt_o), 32'(1));
    checkOutput("lu_flush_cnt", 32'(flush_cnt_o), 32'(0));

    $display("[TB] memory wait of three cycles");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("memwait_stall_cnt", 32'(stall_cnt_o), 32'(4));
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] zero-wait access");
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("zero_wait_stall_cnt", 32'(stall_cnt_o), 32'(4));

    $display("[TB] randomised blocks");
    for (int blk = 0; blk < 8; blk++) begin
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
        applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
                      $urandom_range(0, 1));
      end
    end

    $display("[TB] memory timeout");
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < TB_MAX_WAIT + 1; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("timeout_error", 32'(error_o), 32'(1));
    checkOutput("timeout_freeze", 32'(pipe_freeze_o), 32'(1));
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 1);
    checkOutput("halt_ignores_start", 32'(pc_write_o), 32'(0));
    doReset();
    checkOutput("reset_clears_error", 32'(error_o), 32'(0));

    $display("[TB] flush counter saturation");
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("flush_saturated", 32'(flush_cnt_o), 32'(CNT_MAX));

    $display("[TB] asynchronous reset during memory wait");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    #2;
    rst_i = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst_pc_write",    32'(pc_write_o),    32'(0));
    checkOutput("async_rst_if_id_write", 32'(if_id_write_o), 32'(0));
    checkOutput("async_rst_freeze",      32'(pipe_freeze_o), 32'(1));
    checkOutput("async_rst_stall_cnt",   32'(stall_cnt_o),   32'(0));
    checkOutput("async_rst_flush_cnt",   32'(flush_cnt_o),   32'(0));
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
